// File: rtl/resonator_ddc_control_pkg.sv
// rtl/resonator_ddc_control_pkg.sv - shared constants for the DDC control AXIS stall detector
package resonator_ddc_control_pkg;

  localparam int NUM_AXIS_CH      = 2;
  localparam int DEF_STALL_THRESH = 16;
  localparam int DEF_CNT_W        = 16;

  function automatic int first_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/resonator_ddc_control_axis_block_detect_if.sv
// rtl/resonator_ddc_control_axis_block_detect_if.sv - monitored AXIS handshakes and per-channel block flags
interface resonator_ddc_control_axis_block_detect_if
  import resonator_ddc_control_pkg::*;
#(
  parameter int NUM_CH = NUM_AXIS_CH
);

  logic [NUM_CH-1:0] axis_tvalid;
  logic [NUM_CH-1:0] axis_tready;
  logic [NUM_CH-1:0] axis_block_sigs;

  modport master (
    output axis_tvalid,
    output axis_tready,
    input  axis_block_sigs
  );

  modport slave (
    input  axis_tvalid,
    input  axis_tready,
    output axis_block_sigs
  );

endinterface

// File: rtl/resonator_ddc_control_axis_block_detect_stall_counter.sv
// rtl/resonator_ddc_control_axis_block_detect_stall_counter.sv - single-channel saturating stall run counter and block flag
module axis_stall_counter
  import resonator_ddc_control_pkg::*;
#(
  parameter int STALL_THRESH = DEF_STALL_THRESH,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tvalid,
  input  logic             tready,
  output logic [CNT_W-1:0] run,
  output logic             stall,
  output logic             block
);

  localparam logic [CNT_W-1:0] RUN_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);

  assign stall = tvalid & ~tready;

  // run counts stalled cycles before the current one, so block rises on the STALL_THRESH-th
  always_ff @(posedge clock) begin
    if (reset) begin
      run   <= '0;
      block <= 1'b0;
    end else begin
      block <= stall && (run >= THRESH_M1);
      if (!stall) begin
        run <= '0;
      end else if (run != RUN_MAX) begin
        run <= run + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/resonator_ddc_control_axis_block_detect.sv
// rtl/resonator_ddc_control_axis_block_detect.sv - per-channel AXIS stall detector with sticky, first-offender and longest-stall diagnostics
module resonator_ddc_control_axis_block_detect
  import resonator_ddc_control_pkg::*;
#(
  parameter int NUM_CH       = NUM_AXIS_CH,
  parameter int STALL_THRESH = DEF_STALL_THRESH,
  parameter int CNT_W        = DEF_CNT_W,
  localparam int FIRST_W     = first_w(NUM_CH)
) (
  input  logic                clock,
  input  logic                reset,
  resonator_ddc_control_axis_block_detect_if.slave axis,
  input  logic                clear,
  output logic [NUM_CH-1:0]   block_sticky,
  output logic                first_valid,
  output logic [FIRST_W-1:0]  first_ch,
  output logic [CNT_W-1:0]    max_stall
);

  localparam logic [CNT_W-1:0] RUN_MAX = '1;

  logic [CNT_W-1:0]   run [NUM_CH];
  logic [NUM_CH-1:0]  stall;
  logic [NUM_CH-1:0]  blk;
  logic [CNT_W-1:0]   max_next;
  logic [CNT_W-1:0]   cand;
  logic [FIRST_W-1:0] lowest;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axis_stall_counter #(
      .STALL_THRESH(STALL_THRESH),
      .CNT_W       (CNT_W)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .tvalid(axis.axis_tvalid[g]),
      .tready(axis.axis_tready[g]),
      .run   (run[g]),
      .stall (stall[g]),
      .block (blk[g])
    );
  end

  assign axis.axis_block_sigs = blk;

  // run+1 is the length of the stall including the current cycle
  always_comb begin
    max_next = max_stall;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (stall[i]) begin
        cand = (run[i] == RUN_MAX) ? RUN_MAX : run[i] + CNT_W'(1);
        if (cand > max_next) max_next = cand;
      end
    end
  end

  always_comb begin
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (blk[i]) lowest = FIRST_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      block_sticky <= '0;
      first_valid  <= 1'b0;
      first_ch     <= '0;
      max_stall    <= '0;
    end else begin
      block_sticky <= clear ? blk : (block_sticky | blk);
      if (clear) begin
        first_valid <= 1'b0;
        first_ch    <= '0;
      end else if (!first_valid && (blk != '0)) begin
        first_valid <= 1'b1;
        first_ch    <= lowest;
      end
      max_stall <= clear ? '0 : max_next;
    end
  end

endmodule

// File: tb/tb_resonator_ddc_control_axis_block_detect.sv
// tb/tb_resonator_ddc_control_axis_block_detect.sv - self-checking bench for the AXIS stall detector
module tb_resonator_ddc_control_axis_block_detect;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [1:0] tvalid = 2'b00;
  logic [1:0] tready = 2'b00;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  resonator_ddc_control_axis_block_detect_if #(.NUM_CH(2)) bus0 ();
  resonator_ddc_control_axis_block_detect_if #(.NUM_CH(2)) bus1 ();

  assign bus0.axis_tvalid = tvalid;
  assign bus0.axis_tready = tready;
  assign bus1.axis_tvalid = tvalid;
  assign bus1.axis_tready = tready;

  logic [1:0]  sticky0, sticky1;
  logic        fv0, fv1;
  logic [0:0]  fc0, fc1;
  logic [15:0] max0;
  logic [3:0]  max1;

  resonator_ddc_control_axis_block_detect #(.NUM_CH(2), .STALL_THRESH(16), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .axis(bus0.slave), .clear(clear),
    .block_sticky(sticky0), .first_valid(fv0), .first_ch(fc0), .max_stall(max0)
  );

  resonator_ddc_control_axis_block_detect #(.NUM_CH(2), .STALL_THRESH(3), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .axis(bus1.slave), .clear(clear),
    .block_sticky(sticky1), .first_valid(fv1), .first_ch(fc1), .max_stall(max1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: unbounded stall lengths, saturation applied only when reporting
  int         len [2][2];
  logic [1:0] e_blk [2];
  logic [1:0] e_sticky [2];
  bit         e_fv [2];
  int         e_fc [2];
  int         e_max [2];
  bit         model_ok = 1'b0;
  int         th_v, sat_v;
  logic [1:0] blk_v;
  bit         stall_v;

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      th_v  = (d == 0) ? 16 : 3;
      sat_v = (d == 0) ? 65535 : 15;
      if (reset) begin
        len[d][0] = 0; len[d][1] = 0;
        e_blk[d] = 2'b00; e_sticky[d] = 2'b00;
        e_fv[d] = 1'b0; e_fc[d] = 0; e_max[d] = 0;
      end else begin
        blk_v = e_blk[d];
        e_sticky[d] = clear ? blk_v : (e_sticky[d] | blk_v);
        if (clear) begin
          e_fv[d] = 1'b0; e_fc[d] = 0;
        end else if (!e_fv[d] && blk_v != 2'b00) begin
          e_fv[d] = 1'b1; e_fc[d] = blk_v[0] ? 0 : 1;
        end
        for (int i = 0; i < 2; i++) begin
          stall_v = tvalid[i] && !tready[i];
          len[d][i] = stall_v ? len[d][i] + 1 : 0;
          e_blk[d][i] = stall_v && (len[d][i] >= th_v);
          if (stall_v && ((len[d][i] > sat_v ? sat_v : len[d][i]) > e_max[d]))
            e_max[d] = (len[d][i] > sat_v) ? sat_v : len[d][i];
        end
        if (clear) e_max[d] = 0;
      end
    end
    if (reset) model_ok = 1'b1;
  end

  always @(negedge clock) begin
    if (model_ok) begin
      check("blk0",    int'(bus0.axis_block_sigs), int'(e_blk[0]));
      check("sticky0", int'(sticky0), int'(e_sticky[0]));
      check("fv0",     int'(fv0), int'(e_fv[0]));
      check("fc0",     int'(fc0), e_fc[0]);
      check("max0",    int'(max0), e_max[0]);
      check("blk1",    int'(bus1.axis_block_sigs), int'(e_blk[1]));
      check("sticky1", int'(sticky1), int'(e_sticky[1]));
      check("fv1",     int'(fv1), int'(e_fv[1]));
      check("fc1",     int'(fc1), e_fc[1]);
      check("max1",    int'(max1), e_max[1]);
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; tvalid = 2'b00; tready = 2'b00;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    check("rst_blk0", int'(bus0.axis_block_sigs), 0);
    check("rst_max0", int'(max0), 0);
    check("rst_fv0", int'(fv0), 0);
    do_reset();

    // 1: ch0 stalls 16 cycles
    tvalid = 2'b01; tready = 2'b00;
    step(15);
    check("t1_blk_c15", int'(bus0.axis_block_sigs), 0);
    step(1);
    check("t1_blk_c16", int'(bus0.axis_block_sigs), 1);
    tvalid = 2'b00;
    step(1);
    check("t1_blk_drop", int'(bus0.axis_block_sigs), 0);
    check("t1_sticky", int'(sticky0), 1);
    check("t1_fv", int'(fv0), 1);
    check("t1_fc", int'(fc0), 0);
    check("t1_max", int'(max0), 16);

    // 2: ch1 stalls 15, one idle, 15 more
    do_reset();
    tvalid = 2'b10;
    step(15);
    tvalid = 2'b00;
    step(1);
    tvalid = 2'b10;
    step(15);
    tvalid = 2'b00;
    step(1);
    check("t2_max", int'(max0), 15);
    check("t2_fv", int'(fv0), 0);
    check("t2_sticky", int'(sticky0), 0);

    // 3: both channels stall together for 20 cycles
    do_reset();
    tvalid = 2'b11;
    step(16);
    check("t3_blk_both", int'(bus0.axis_block_sigs), 3);
    step(4);
    check("t3_fc", int'(fc0), 0);
    check("t3_fv", int'(fv0), 1);
    check("t3_sticky", int'(sticky0), 3);
    tvalid = 2'b00;
    step(1);
    check("t3_drop", int'(bus0.axis_block_sigs), 0);

    // 4: clear lands in the first cycle ch1 is blocked
    do_reset();
    tvalid = 2'b10;
    step(16);
    check("t4_blk", int'(bus0.axis_block_sigs), 2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t4_sticky_kept", int'(sticky0), 2);
    check("t4_fv_cleared", int'(fv0), 0);
    check("t4_max_cleared", int'(max0), 0);
    step(1);
    check("t4_fv_recap", int'(fv0), 1);
    check("t4_fc_recap", int'(fc0), 1);
    check("t4_max_restart", int'(max0), 18);
    tvalid = 2'b00;
    step(1);

    // 5: 40-cycle stall on ch0; the small instance saturates
    do_reset();
    tvalid = 2'b01;
    step(40);
    check("t5_max1_sat", int'(max1), 15);
    check("t5_blk1_held", int'(bus1.axis_block_sigs), 1);
    tready = 2'b01;
    step(1);
    check("t5_blk1_drop", int'(bus1.axis_block_sigs), 0);
    check("t5_max0", int'(max0), 40);
    tvalid = 2'b00; tready = 2'b00;
    step(1);

    // 6: reset mid-stall at run=10, stall keeps going
    do_reset();
    tvalid = 2'b01;
    step(10);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t6_rst_blk", int'(bus0.axis_block_sigs), 0);
    check("t6_rst_max", int'(max0), 0);
    check("t6_rst_sticky", int'(sticky0), 0);
    step(15);
    check("t6_blk_c15", int'(bus0.axis_block_sigs), 0);
    step(1);
    check("t6_blk_c16", int'(bus0.axis_block_sigs), 1);
    tvalid = 2'b00;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
